// File: rtl/dcache_sram_nway_if.sv
// Bus bundle between the data-cache controller and the N-way storage array.
// The slave modport is the array side; the master modport is the controller side.
interface dcache_sram_nway_if #(
   parameter int WAYS   = 2,
   parameter int SETS   = 16,
   parameter int TAG_W  = 23,
   parameter int LINE_W = 256
);
   localparam int SET_W = $clog2(SETS);

   logic                enable_i;
   logic                write_i;
   logic [SET_W-1:0]    addr_i;
   logic [TAG_W-1:0]    tag_i;
   logic [LINE_W-1:0]   data_i;
   logic                hit_o;
   logic [TAG_W+1:0]    tag_o;
   logic [LINE_W-1:0]   data_o;
   logic                flush_i;
   logic                inv_i;
   logic                busy_o;
   logic                wb_valid_o;
   logic                wb_ready_i;
   logic [SET_W-1:0]    wb_set_o;
   logic [TAG_W-1:0]    wb_tag_o;
   logic [LINE_W-1:0]   wb_data_o;
   logic                flush_done_o;

   modport slave (
      input  enable_i, write_i, addr_i, tag_i, data_i, flush_i, inv_i, wb_ready_i,
      output hit_o, tag_o, data_o, busy_o, wb_valid_o, wb_set_o, wb_tag_o, wb_data_o,
             flush_done_o
   );

   modport master (
      output enable_i, write_i, addr_i, tag_i, data_i, flush_i, inv_i, wb_ready_i,
      input  hit_o, tag_o, data_o, busy_o, wb_valid_o, wb_set_o, wb_tag_o, wb_data_o,
             flush_done_o
   );
endinterface

// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage with true-LRU ages and a flush /
// write-back walker that streams dirty lines out over a valid/ready port.
module dcache_sram_nway #(
   parameter int WAYS   = 2,
   parameter int SETS   = 16,
   parameter int TAG_W  = 23,
   parameter int LINE_W = 256
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   dcache_sram_nway_if.slave  bus
);
   localparam int SET_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int IDX_W = SET_W + WAY_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS*WAYS-1);
   localparam logic [WAY_W-1:0] OLDEST   = WAY_W'(WAYS-1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WB, S_DONE} state_t;

   logic              r_valid [SETS][WAYS];
   logic              r_dirty [SETS][WAYS];
   logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
   logic [LINE_W-1:0] r_data  [SETS][WAYS];
   logic [WAY_W-1:0]  r_age   [SETS][WAYS];

   state_t            r_state;
   logic [IDX_W-1:0]  r_idx;
   logic              r_inv;
   logic              r_busy;
   logic              r_wb_valid;
   logic              r_flush_done;
   logic [SET_W-1:0]  r_wb_set;
   logic [TAG_W-1:0]  r_wb_tag;
   logic [LINE_W-1:0] r_wb_data;

   logic [SET_W-1:0]  w_addr;
   logic [WAYS-1:0]   w_hit_vec;
   logic [WAYS-1:0]   w_inv_vec;
   logic [WAYS-1:0]   w_old_vec;
   logic [WAY_W-1:0]  w_hit_way;
   logic [WAY_W-1:0]  w_victim_way;
   logic [WAY_W-1:0]  w_sel_way;
   logic [WAY_W-1:0]  w_sel_age;
   logic [WAY_W-1:0]  w_age_next [WAYS];
   logic              w_hit;
   logic              w_access;
   logic              w_touch;
   logic              w_wr;
   logic              w_fill;
   logic [SET_W-1:0]  w_scan_set;
   logic [WAY_W-1:0]  w_scan_way;
   logic              w_scan_dirty;
   logic              w_wb_hs;
   logic              w_wlk_clr_valid;
   logic              w_wlk_clr_dirty;

   assign w_addr = bus.addr_i;

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_lookup
         assign w_hit_vec[gi] = r_valid[w_addr][gi] && (r_tag[w_addr][gi] == bus.tag_i);
         assign w_inv_vec[gi] = !r_valid[w_addr][gi];
         assign w_old_vec[gi] = (r_age[w_addr][gi] == OLDEST);
         // Touching the selected way: it becomes youngest, younger ways age by one.
         assign w_age_next[gi] = (w_sel_way == WAY_W'(gi)) ? '0 :
                                 (r_age[w_addr][gi] < w_sel_age) ? r_age[w_addr][gi] + 1'b1 :
                                 r_age[w_addr][gi];
      end
   endgenerate

   // Descending scans so the lowest matching index wins.
   always_comb begin
      w_hit_way    = '0;
      w_victim_way = '0;
      for (int i = WAYS-1; i >= 0; i--) begin
         if (w_hit_vec[i]) w_hit_way = WAY_W'(i);
      end
      if (|w_inv_vec) begin
         for (int i = WAYS-1; i >= 0; i--) begin
            if (w_inv_vec[i]) w_victim_way = WAY_W'(i);
         end
      end else begin
         for (int i = WAYS-1; i >= 0; i--) begin
            if (w_old_vec[i]) w_victim_way = WAY_W'(i);
         end
      end
   end

   assign w_hit     = |w_hit_vec;
   assign w_sel_way = w_hit ? w_hit_way : w_victim_way;
   assign w_sel_age = r_age[w_addr][w_sel_way];

   assign bus.hit_o  = w_hit;
   assign bus.tag_o  = {r_valid[w_addr][w_sel_way], r_dirty[w_addr][w_sel_way],
                        r_tag[w_addr][w_sel_way]};
   assign bus.data_o = r_data[w_addr][w_sel_way];

   assign w_access = bus.enable_i && (r_state == S_IDLE);
   assign w_touch  = w_access && (w_hit || bus.write_i);
   assign w_wr     = w_access && bus.write_i;
   assign w_fill   = w_wr && !w_hit;

   assign w_scan_set      = r_idx[IDX_W-1:WAY_W];
   assign w_scan_way      = r_idx[WAY_W-1:0];
   assign w_scan_dirty    = r_valid[w_scan_set][w_scan_way] && r_dirty[w_scan_set][w_scan_way];
   assign w_wb_hs         = (r_state == S_WB) && bus.wb_ready_i;
   assign w_wlk_clr_dirty = w_wb_hs;
   assign w_wlk_clr_valid = r_inv && (((r_state == S_SCAN) && !w_scan_dirty) || w_wb_hs);

   // Walker and access updates never coincide: accesses only land in IDLE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               r_valid[s][w] <= 1'b0;
               r_dirty[s][w] <= 1'b0;
               r_tag[s][w]   <= '0;
               r_data[s][w]  <= '0;
               r_age[s][w]   <= WAY_W'(w);
            end
         end
      end else begin
         if (w_wlk_clr_valid) r_valid[w_scan_set][w_scan_way] <= 1'b0;
         if (w_wlk_clr_dirty) r_dirty[w_scan_set][w_scan_way] <= 1'b0;
         if (w_wr) begin
            r_data[w_addr][w_sel_way] <= bus.data_i;
            if (w_fill) begin
               r_valid[w_addr][w_sel_way] <= 1'b1;
               r_dirty[w_addr][w_sel_way] <= 1'b0;
               r_tag[w_addr][w_sel_way]   <= bus.tag_i;
            end else begin
               r_dirty[w_addr][w_sel_way] <= 1'b1;
            end
         end
         if (w_touch) begin
            for (int w = 0; w < WAYS; w++) begin
               r_age[w_addr][w] <= w_age_next[w];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_inv        <= 1'b0;
         r_busy       <= 1'b0;
         r_wb_valid   <= 1'b0;
         r_flush_done <= 1'b0;
         r_wb_set     <= '0;
         r_wb_tag     <= '0;
         r_wb_data    <= '0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.flush_i) begin
                  r_state <= S_SCAN;
                  r_inv   <= bus.inv_i;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_SCAN: begin
               if (w_scan_dirty) begin
                  r_state    <= S_WB;
                  r_wb_valid <= 1'b1;
                  r_wb_set   <= w_scan_set;
                  r_wb_tag   <= r_tag[w_scan_set][w_scan_way];
                  r_wb_data  <= r_data[w_scan_set][w_scan_way];
               end else if (r_idx == LAST_IDX) begin
                  r_state      <= S_DONE;
                  r_flush_done <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_WB: begin
               if (bus.wb_ready_i) begin
                  r_wb_valid <= 1'b0;
                  if (r_idx == LAST_IDX) begin
                     r_state      <= S_DONE;
                     r_flush_done <= 1'b1;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= S_SCAN;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o       = r_busy;
   assign bus.wb_valid_o   = r_wb_valid;
   assign bus.wb_set_o     = r_wb_set;
   assign bus.wb_tag_o     = r_wb_tag;
   assign bus.wb_data_o    = r_wb_data;
   assign bus.flush_done_o = r_flush_done;
endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed bench for dcache_sram_nway (4 ways, 16 sets): lookups, LRU
// replacement, hit writes, flush with write-back stall, invalidating flush, reset mid-walk.
module tb_dcache_sram_nway;
   localparam int WAYS   = 4;
   localparam int SETS   = 16;
   localparam int TAG_W  = 23;
   localparam int LINE_W = 256;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   dcache_sram_nway_if #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) bus ();

   dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Free-running monitors; the main sequence takes snapshots and differences.
   int               hs_n = 0;
   logic [3:0]       hs_set [16];
   logic [TAG_W-1:0] hs_tag [16];
   int               busy_cyc = 0;
   int               wbv_cyc  = 0;
   int               done_cyc = 0;

   always @(posedge clk_i) begin
      if (rst_ni && bus.wb_valid_o && bus.wb_ready_i) begin
         hs_set[hs_n[3:0]] = bus.wb_set_o;
         hs_tag[hs_n[3:0]] = bus.wb_tag_o;
         hs_n++;
      end
   end

   always @(negedge clk_i) begin
      if (bus.busy_o)       busy_cyc++;
      if (bus.wb_valid_o)   wbv_cyc++;
      if (bus.flush_done_o) done_cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [299:0] obs, input logic [299:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
         $display("check %s ok", name);
      end else begin
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni          = 1'b0;
      bus.enable_i    = 1'b0;
      bus.write_i     = 1'b0;
      bus.addr_i      = '0;
      bus.tag_i       = '0;
      bus.data_i      = '0;
      bus.flush_i     = 1'b0;
      bus.inv_i       = 1'b0;
      bus.wb_ready_i  = 1'b0;
      repeat (2) @(posedge clk_i);
      #3 rst_ni = 1'b1;
      tick();
   endtask

   task automatic access(input logic wr, input logic [3:0] s, input logic [TAG_W-1:0] t,
                         input logic [LINE_W-1:0] d);
      bus.enable_i = 1'b1;
      bus.write_i  = wr;
      bus.addr_i   = s;
      bus.tag_i    = t;
      bus.data_i   = d;
      tick();
      bus.enable_i = 1'b0;
      bus.write_i  = 1'b0;
      $display("access wr=%0d set=%0d tag=%0h", wr, s, t);
   endtask

   task automatic look(input logic [3:0] s, input logic [TAG_W-1:0] t);
      bus.enable_i = 1'b0;
      bus.addr_i   = s;
      bus.tag_i    = t;
      #1;
   endtask

   logic [LINE_W-1:0] d0, dead, dx, dy, d4;
   int k, hs0, b0, w0, c0;

   initial begin
      d0   = {8{32'h0123_4567}};
      dead = {16{16'hDEAD}};
      dx   = {8{32'hA5A5_0001}};
      dy   = {8{32'h5A5A_0002}};
      d4   = {8{32'hC0DE_0004}};

      // Reset state and first fill
      do_reset();
      chk("rst_busy",     bus.busy_o, 1'b0);
      chk("rst_wb_valid", bus.wb_valid_o, 1'b0);
      chk("rst_done",     bus.flush_done_o, 1'b0);
      chk("rst_wb_bus",   {bus.wb_set_o, bus.wb_tag_o, bus.wb_data_o}, '0);
      look(4'd3, 23'h12);
      chk("rst_hit",   bus.hit_o, 1'b0);
      chk("rst_tag_o", bus.tag_o, '0);
      chk("rst_data_o", bus.data_o, '0);
      access(1'b1, 4'd3, 23'h12, d0);
      look(4'd3, 23'h12);
      chk("fill_hit",   bus.hit_o, 1'b1);
      chk("fill_tag_o", bus.tag_o, {1'b1, 1'b0, 23'h12});
      chk("fill_data",  bus.data_o, d0);

      // LRU: A,B,C,D fill set 5, read A, fill E -> E evicts B
      access(1'b1, 4'd5, 23'h100, {8{32'hAAAA_AAAA}});
      access(1'b1, 4'd5, 23'h200, {8{32'hBBBB_BBBB}});
      access(1'b1, 4'd5, 23'h300, {8{32'hCCCC_CCCC}});
      access(1'b1, 4'd5, 23'h400, {8{32'hDDDD_DDDD}});
      access(1'b0, 4'd5, 23'h100, '0);
      access(1'b1, 4'd5, 23'h500, {8{32'hEEEE_EEEE}});
      look(4'd5, 23'h100); chk("lru_hit_A", bus.hit_o, 1'b1);
      look(4'd5, 23'h300); chk("lru_hit_C", bus.hit_o, 1'b1);
      look(4'd5, 23'h400); chk("lru_hit_D", bus.hit_o, 1'b1);
      look(4'd5, 23'h500); chk("lru_hit_E", bus.hit_o, 1'b1);
      chk("lru_data_E", bus.data_o, {8{32'hEEEE_EEEE}});
      tick();
      look(4'd5, 23'h200); chk("lru_miss_B", bus.hit_o, 1'b0);
      chk("lru_victim", bus.tag_o, {1'b1, 1'b0, 23'h300});

      // Write hit makes the line dirty
      access(1'b1, 4'd5, 23'h300, dead);
      look(4'd5, 23'h300);
      chk("wrhit_tag_o", bus.tag_o, {1'b1, 1'b1, 23'h300});
      chk("wrhit_data",  bus.data_o, dead);

      // Flush, no invalidate, two dirty lines, first one stalled
      do_reset();
      access(1'b1, 4'd0, 23'h10, '0);
      access(1'b1, 4'd0, 23'h11, '0);
      access(1'b1, 4'd0, 23'h11, dx);
      access(1'b1, 4'd9, 23'h20, '0);
      access(1'b1, 4'd9, 23'h21, '0);
      access(1'b1, 4'd9, 23'h22, '0);
      access(1'b1, 4'd9, 23'h22, dy);
      hs0 = hs_n;
      c0  = done_cyc;
      bus.wb_ready_i = 1'b0;
      bus.inv_i      = 1'b0;
      bus.flush_i    = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk("fl_busy_rise", bus.busy_o, 1'b1);
      k = 0;
      while (!bus.wb_valid_o && k < 200) begin tick(); k++; end
      chk("fl_wb1_seen",  bus.wb_valid_o, 1'b1);
      chk("fl_wb1_lat",   k, 2);
      chk("fl_wb1_set",   bus.wb_set_o, 4'd0);
      chk("fl_wb1_tag",   bus.wb_tag_o, 23'h11);
      chk("fl_wb1_data",  bus.wb_data_o, dx);
      repeat (3) begin
         tick();
         chk("fl_stall", {bus.wb_valid_o, bus.wb_set_o, bus.wb_tag_o, bus.wb_data_o},
             {1'b1, 4'd0, 23'h11, dx});
      end
      bus.wb_ready_i = 1'b1;
      tick();
      k = 0;
      while (!bus.flush_done_o && k < 400) begin tick(); k++; end
      chk("fl_done_seen", bus.flush_done_o, 1'b1);
      tick();
      chk("fl_done_pulse", bus.flush_done_o, 1'b0);
      chk("fl_busy_fall",  bus.busy_o, 1'b0);
      chk("fl_hs_count",   hs_n - hs0, 2);
      chk("fl_hs0_set",    hs_set[hs0[3:0]], 4'd0);
      chk("fl_hs0_tag",    hs_tag[hs0[3:0]], 23'h11);
      hs0 = hs0 + 1;
      chk("fl_hs1_set",    hs_set[hs0[3:0]], 4'd9);
      chk("fl_hs1_tag",    hs_tag[hs0[3:0]], 23'h22);
      chk("fl_done_count", done_cyc - c0, 1);
      bus.wb_ready_i = 1'b0;
      look(4'd0, 23'h11);
      chk("fl_clean_s0", {bus.hit_o, bus.tag_o}, {1'b1, 1'b1, 1'b0, 23'h11});
      look(4'd9, 23'h22);
      chk("fl_clean_s9", {bus.hit_o, bus.tag_o}, {1'b1, 1'b1, 1'b0, 23'h22});
      chk("fl_keep_data", bus.data_o, dy);

      // Invalidating flush, nothing dirty
      do_reset();
      access(1'b1, 4'd2, 23'h7, d0);
      access(1'b1, 4'd15, 23'h9, d0);
      b0 = busy_cyc;
      w0 = wbv_cyc;
      c0 = done_cyc;
      bus.inv_i   = 1'b1;
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      bus.inv_i   = 1'b0;
      k = 0;
      while (bus.busy_o && k < 200) begin tick(); k++; end
      chk("inv_busy_idle",  bus.busy_o, 1'b0);
      chk("inv_busy_cycles", busy_cyc - b0, 65);
      chk("inv_no_wb",      wbv_cyc - w0, 0);
      chk("inv_done_count", done_cyc - c0, 1);
      look(4'd2, 23'h7);  chk("inv_miss_s2",  bus.hit_o, 1'b0);
      look(4'd15, 23'h9); chk("inv_miss_s15", bus.hit_o, 1'b0);

      // Reset asserted while a write-back is pending
      do_reset();
      access(1'b1, 4'd4, 23'h33, '0);
      access(1'b1, 4'd4, 23'h33, d4);
      bus.wb_ready_i = 1'b0;
      bus.flush_i    = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      k = 0;
      while (!bus.wb_valid_o && k < 200) begin tick(); k++; end
      chk("rw_wb_seen", bus.wb_valid_o, 1'b1);
      c0 = done_cyc;
      #2 rst_ni = 1'b0;
      #1;
      chk("rw_wb_drop",   bus.wb_valid_o, 1'b0);
      chk("rw_busy_drop", bus.busy_o, 1'b0);
      @(posedge clk_i);
      #2 rst_ni = 1'b1;
      tick();
      tick();
      chk("rw_no_done", done_cyc - c0, 0);
      look(4'd4, 23'h33);
      chk("rw_miss", bus.hit_o, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/dcache_sram_nway.md
# dcache_sram_nway

Parametrised N-way set-associative data-cache storage array with true-LRU replacement and a built-in flush/write-back walker. It sits between the data-cache controller and the memory interface: it answers the controller's same-cycle lookups and performs hit writes and line fills. On request, it walks every line and streams dirty lines out through a valid/ready write-back port, optionally invalidating the cache as it goes.

## Interface
- WAYS, 2, associativity; power of two, 2..8
- SETS, 16, number of sets; power of two, >=2
- TAG_W, 23, address-tag width (excludes valid/dirty)
- LINE_W, 256, line width in bits
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- enable_i  in  1  access request this cycle
- write_i  in  1  with enable_i: write (hit write or fill); else read
- addr_i  in  log2(SETS)  set index
- tag_i  in  TAG_W  lookup/write tag
- data_i  in  LINE_W  write/fill data
- hit_o  out  1  valid way in set addr_i holds tag_i (combinational)
- tag_o  out  TAG_W+2  {valid, dirty, tag} of hit way, else of victim way
- data_o  out  LINE_W  line of hit way, else of victim way
- flush_i  in  1  start flush (one-cycle pulse, sampled in IDLE only)
- inv_i  in  1  sampled with flush_i: invalidate every line during the walk
- busy_o  out  1  walker active; accesses ignored
- wb_valid_o  out  1  dirty line presented
- wb_ready_i  in  1  consumer accepts line
- wb_set_o  out  log2(SETS)  set of presented line
- wb_tag_o  out  TAG_W  tag of presented line
- wb_data_o  out  LINE_W  data of presented line
- flush_done_o  out  1  one-cycle pulse at walk end

## Operation
- Per line: valid, dirty, tag, data. Per way per set: age counter, log2(WAYS) bits. Ages within a set are always a permutation of 0..WAYS-1.
- Victim: lowest-index invalid way. If all ways are valid, the way with age WAYS-1.
- Touch way w: every way with age < age[w] is incremented; age[w] is set to 0.
- Read hit (enable_i, !write_i, hit_o): touch hit way. Read miss changes nothing.
- Write hit (enable_i, write_i, hit_o): data <= data_i, dirty <= 1, touch.
- Fill (enable_i, write_i, !hit_o): victim way gets valid=1, dirty=0, tag=tag_i, data=data_i; touch. The controller writes back a dirty victim (seen on tag_o/data_o) before the fill.
- Walker states:
  - IDLE → SCAN on flush_i; captures inv_i and clears the entry index.
  - SCAN, entry (set s, way w), index = s*WAYS+w:
    - valid&dirty → WB.
    - otherwise: if inv, clear valid; at the last index → DONE, else index+1.
  - WB: wb_valid_o=1, wb_* show the entry, held stable until wb_ready_i. On handshake: dirty <= 0, valid <= 0 if inv; → DONE if last index, else index+1 and → SCAN.
  - DONE: flush_done_o=1 for one cycle → IDLE.
- busy_o = state != IDLE. While busy, enable_i and flush_i are ignored. The walker does not change ages; after an inv flush, ages are unchanged.

## Timing
- Lookup outputs are combinational from addr_i/tag_i and array state. Writes and age updates take effect at the next edge.
- Reset: all valid/dirty/tag/data = 0, age[w]=w in every set, state IDLE. Outputs hit_o=0, tag_o=0, data_o=0, busy_o=0, wb_valid_o=0, flush_done_o=0, wb_set_o/wb_tag_o/wb_data_o=0.
- Access and flush_i in the same IDLE cycle: the access completes; busy_o rises next cycle.
- flush_i to busy_o: 1 cycle. Each clean entry costs 1 SCAN cycle. Each dirty entry costs 1 SCAN cycle + ≥1 WB cycle. wb_valid_o rises the cycle after SCAN sees the dirty entry.
- Flush with no dirty lines: busy_o high for SETS*WAYS+1 cycles, with flush_done_o in the last.
- wb_ready_i high before wb_valid_o: handshake in the first WB cycle.
- rst_ni asserted mid-walk: immediate return to IDLE, wb_valid_o drops asynchronously, no flush_done_o.

## Test plan
- Reset (WAYS=4, SETS=16) → read set 3, tag 0x12 → hit_o=0, tag_o=0. Fill tag 0x12 → next cycle hit_o=1, tag_o={1,0,0x12}.
- Fill tags A,B,C,D into set 5, read A, fill E → E replaces B (oldest); A,C,D,E hit, B misses.
- Write hit on set 5 tag C with data 0xDEAD… → tag_o dirty=1, data_o=0xDEAD….
- Two dirty lines (set 0 way 1, set 9 way 2), flush_i with inv_i=0, wb_ready_i held low 3 cycles on the first → exactly two write-back handshakes in that order, data stable while stalled. Afterwards: lines valid and clean, flush_done_o one pulse.
- Flush with inv_i=1, no dirty lines → busy_o high 65 cycles, no wb_valid_o. Afterwards every lookup misses.
- rst_ni low during WB → wb_valid_o=0 immediately, busy_o=0. After release, all lookups miss.
